dmem_pipelined: RTL

Parametrised, pipelined data memory for the datapath's load/store stage. It replaces the fixed 64×32 single-port array with configurable width and depth. It adds a valid/ready request port, per-byte write strobes and a configurable read latency, and it flags out-of-range addresses. An optional post-reset clear sweep zeroes the array before the first request is accepted.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_latency_pipe.sv | 36 +++
 rtl/dmem_pipelined.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types, latency limits and sizing helpers for the pipelined data memory.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int offset_width(input int dw);
        return (dw > 8) ? $clog2(dw / 8) : 0;
    endfunction

endpackage

// File: rtl/dmem_latency_pipe.sv
// Valid + payload shift register used as the fixed-latency read response path.
module dmem_latency_pipe #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 33
) (
    input  logic             Clock,
    input  logic             ResetL,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];

    always_ff @(posedge Clock or negedge ResetL) begin
        if (!ResetL) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/dmem_pipelined.sv
// Pipelined byte-strobed data memory with valid/ready requests.
// Define DMEM_INIT_CLEAR_EN to zero the array after every reset.
module dmem_pipelined
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                    Clock,
    input  logic                    ResetL,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] ByteEnable,
    output logic                    RespValid,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    RespError
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int OFFW  = offset_width(DATA_WIDTH);
    localparam int IDXW  = ADDR_WIDTH - OFFW;
    localparam int AIW   = index_width(DEPTH);

    generate
        if (READ_LATENCY < MIN_READ_LATENCY ||
            READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
            $error("dmem_pipelined: READ_LATENCY out of range");
        end
        if (OFFW > 0) begin : g_off
            logic w_unused_off;
            assign w_unused_off = ^Address[OFFW-1:0];
        end
    endgenerate

`ifdef DMEM_INIT_CLEAR_EN
    localparam state_t RESET_STATE = INIT;
    logic [AIW-1:0] r_clr_cnt;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t                r_state;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_resp_err;

    logic                  w_accept;
    logic [IDXW-1:0]       w_index;
    logic [AIW-1:0]        w_word;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_pipe_valid;
    logic [DATA_WIDTH:0]   w_pipe_data;

    assign w_accept   = ReqValid && r_ready;
    assign w_index    = Address[ADDR_WIDTH-1:OFFW];
    assign w_word     = w_index[AIW-1:0];
    assign w_in_range = (w_index < IDXW'(DEPTH));
    assign w_rd_word  = w_in_range ? r_mem[w_word] : '0;

    always_ff @(posedge Clock or negedge ResetL) begin
        if (!ResetL) begin
            r_state <= RESET_STATE;
            r_ready <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
            r_clr_cnt <= '0;
`endif
        end else begin
            unique case (r_state)
                INIT: begin
`ifdef DMEM_INIT_CLEAR_EN
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == AIW'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
`endif
                end
                RUN: r_ready <= 1'b1;
            endcase
        end
    end

    // Array storage is deliberately not reset; only the clear sweep zeroes it.
    always_ff @(posedge Clock) begin
`ifdef DMEM_INIT_CLEAR_EN
        if (r_state == INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else
`endif
        if (w_accept && ReqWrite && w_in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (ByteEnable[i]) begin
                    r_mem[w_word][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    dmem_latency_pipe #(
        .STAGES (READ_LATENCY),
        .WIDTH  (DATA_WIDTH + 1)
    ) u_rd_pipe (
        .Clock   (Clock),
        .ResetL  (ResetL),
        .i_valid (w_accept && !ReqWrite),
        .i_data  ({!w_in_range, w_rd_word}),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data)
    );

    always_ff @(posedge Clock or negedge ResetL) begin
        if (!ResetL) begin
            r_resp_valid <= 1'b0;
            r_rd_data    <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_pipe_valid;
            if (w_pipe_valid) begin
                r_resp_err <= w_pipe_data[DATA_WIDTH];
                r_rd_data  <= w_pipe_data[DATA_WIDTH-1:0];
            end
        end
    end

    assign ReqReady  = r_ready;
    assign RespValid = r_resp_valid;
    assign ReadData  = r_rd_data;
    assign RespError = r_resp_err;

endmodule
